ac_ctrl: RTL and testbench

AC_CTRL -- requirements
Module: ac_ctrl

---
 rtl/ac_pkg.sv | 32 +++
 rtl/ac_ctrl_decode.sv | 52 +++++
 rtl/ac_ctrl.sv | 99 +++++++++
 tb/tb_ac_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator machine controller.
//   state_t    : controller FSM states
//   OP_*       : opcode field values (instr[DATA_W-1:DATA_W-4])
//   ALU_*      : alu_op encodings driven to the datapath ALU
//   is_mem_op  : opcodes that need an EXEC cycle with a data memory access
package ac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ac_ctrl_decode.sv
// Combinational strobe decode for ac_ctrl.
// Inputs are only the registered FSM state and instruction register, so no
// path exists from any ac_ctrl input to the strobes.
//   state    : current FSM state (state_t encoding)
//   ir       : latched instruction word
//   mem_addr : operand address in EXEC, else 0
//   mem_rd / mem_wr / wac / rac : datapath strobes, EXEC only
//   alu_op   : ALU function in EXEC, else PASS (0)
//   busy / halted : status derived from state
module ac_ctrl_decode
  import ac_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic [2:0]        state,
  input  logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              wac,
  output logic              rac,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              halted
);

  logic [3:0] opcode;
  assign opcode = ir[DATA_W-1 -: 4];

  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    wac      = 1'b0;
    rac      = 1'b0;
    alu_op   = ALU_PASS;
    busy     = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
    halted   = (state == ST_HALT);
    if (state == ST_EXEC) begin
      mem_addr = ir[ADDR_W-1:0];
      case (opcode)
        OP_LDA: begin mem_rd = 1'b1; wac = 1'b1; alu_op = ALU_PASS; end
        OP_ADD: begin mem_rd = 1'b1; wac = 1'b1; alu_op = ALU_ADD;  end
        OP_SUB: begin mem_rd = 1'b1; wac = 1'b1; alu_op = ALU_SUB;  end
        OP_STA: begin rac    = 1'b1; mem_wr = 1'b1;                 end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ac_ctrl.sv
// Accumulator machine controller: program counter, instruction register and
// sequencing FSM. Strobes come from ac_ctrl_decode.
//   clk, reset (sync, active high), start (one-cycle run request)
//   instr  : program memory data at pc;  zero : accumulator == 0
//   pc, mem_addr, mem_rd, mem_wr, wac, rac, alu_op, busy, halted : outputs
//
// state  | meaning
// IDLE   | waiting for start; pc held at 0
// FETCH  | IR <= instr, pc <= pc + 1
// DECODE | branch resolution / dispatch on opcode
// EXEC   | one data memory access cycle (LDA/STA/ADD/SUB)
// HALT   | stopped on HLT, left only by reset
module ac_ctrl
  import ac_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              wac,
  output logic              rac,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [3:0]        opcode;

  assign opcode = ir[DATA_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= '0;
          end
        end
        ST_FETCH: begin
          ir    <= instr;
          pc    <= pc + PC_ONE;   // natural wrap at 2^ADDR_W
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_mem_op(opcode)) begin
            state <= ST_EXEC;
          end else if (opcode == OP_JMP) begin
            pc    <= ir[ADDR_W-1:0];
            state <= ST_FETCH;
          end else if (opcode == OP_JZ) begin
            if (zero) pc <= ir[ADDR_W-1:0];
            state <= ST_FETCH;
          end else if (opcode == OP_HLT) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_EXEC:  state <= ST_FETCH;
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ac_ctrl_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .state    (state),
    .ir       (ir),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .wac      (wac),
    .rac      (rac),
    .alu_op   (alu_op),
    .busy     (busy),
    .halted   (halted)
  );

endmodule

// File: tb/tb_ac_ctrl.sv
module tb_ac_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       zero;
  logic [3:0] pc;
  logic [3:0] mem_addr;
  logic       mem_rd, mem_wr, wac, rac;
  logic [1:0] alu_op;
  logic       busy, halted;

  logic [7:0]  prog [16];
  logic [15:0] sb [$];
  logic [15:0] obs;
  logic [15:0] exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  ac_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .instr    (instr),
    .zero     (zero),
    .pc       (pc),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .wac      (wac),
    .rac      (rac),
    .alu_op   (alu_op),
    .busy     (busy),
    .halted   (halted)
  );

  assign instr = prog[pc];
  assign obs   = {pc, mem_addr, mem_rd, mem_wr, wac, rac, alu_op, busy, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(wac === 1'b1 && rac === 1'b1))
      else begin n_fail++; $display("FAIL wac_rac_excl: wac=%b rac=%b both high", wac, rac); end
    assert (!(mem_rd === 1'b1 && mem_wr === 1'b1))
      else begin n_fail++; $display("FAIL rd_wr_excl: mem_rd=%b mem_wr=%b both high", mem_rd, mem_wr); end
  end

  // expected output vector: {pc, mem_addr, rd, wr, wac, rac, alu_op, busy, halted}
  function automatic logic [15:0] ev(input logic [3:0] p, input logic [3:0] a,
                                     input logic rd, input logic wr, input logic w,
                                     input logic r, input logic [1:0] op,
                                     input logic b, input logic h);
    return {p, a, rd, wr, w, r, op, b, h};
  endfunction
  function automatic logic [15:0] fd(input logic [3:0] p);   // FETCH/DECODE
    return ev(p, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
  endfunction
  function automatic logic [15:0] hl(input logic [3:0] p);   // HALT
    return ev(p, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
  endfunction
  localparam logic [15:0] IDLE_V = 16'h0000;

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; zero = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_prog();
    reset = 1'b1; start = 1'b1;
    sb.push_back(IDLE_V);
    sb.push_back(IDLE_V);
    sb.push_back(IDLE_V);
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      reset = 1'b0; start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_lda();
    do_reset(); clear_prog();
    prog[0] = 8'h15;
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(ev(4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0));
    sb.push_back(fd(4'd1));
    sb.push_back(fd(4'd2));
    sb.push_back(hl(4'd2));
    start = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL lda: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_sta();
    do_reset(); clear_prog();
    prog[0] = 8'h29;
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(ev(4'd1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0));
    sb.push_back(fd(4'd1));
    sb.push_back(fd(4'd2));
    sb.push_back(hl(4'd2));
    start = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL sta: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_sub();
    do_reset(); clear_prog();
    prog[0] = 8'h4A;
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(ev(4'd1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0));
    sb.push_back(fd(4'd1));
    start = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL sub: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_jz(input logic zero_v);
    logic [3:0] tgt;
    do_reset(); clear_prog();
    prog[0] = 8'h54;           // JMP 4
    prog[4] = 8'h63;           // JZ 3
    tgt = zero_v ? 4'd3 : 4'd5;
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(fd(4'd4));
    sb.push_back(fd(4'd5));
    sb.push_back(fd(tgt));
    sb.push_back(fd(tgt + 4'd1));
    sb.push_back(hl(tgt + 4'd1));
    zero = zero_v; start = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL jz(zero=%b): got %h want %h", zero_v, obs, exp_v); end
    end
    zero = 1'b0;
  endtask

  task automatic test_pc_wrap();
    int cyc;
    do_reset(); clear_prog();
    prog[0]  = 8'h5F;          // JMP 15, replaced by HLT once latched
    prog[15] = 8'h00;          // NOP
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(fd(4'd15));
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(hl(4'd1));
    start = 1'b1; cyc = 0;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v); end
      if (cyc == 1) prog[0] = 8'hF0;
      cyc++;
    end
  endtask

  task automatic test_halt();
    int cyc;
    do_reset(); clear_prog();
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(hl(4'd1));
    sb.push_back(hl(4'd1));
    sb.push_back(hl(4'd1));
    sb.push_back(hl(4'd1));
    sb.push_back(IDLE_V);
    sb.push_back(IDLE_V);
    start = 1'b1; cyc = 0;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL halt: got %h want %h", obs, exp_v); end
      cyc++;
      start = (cyc >= 3 && cyc <= 5);
      reset = (cyc == 6);
    end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    int cyc;
    do_reset(); clear_prog();
    prog[0] = 8'h37;
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(ev(4'd1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0));
    sb.push_back(IDLE_V);
    sb.push_back(IDLE_V);
    start = 1'b1; cyc = 0;
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_in_exec: got %h want %h", obs, exp_v); end
      reset = (cyc == 2);
      cyc++;
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_prog();
    prog[0] = 8'h12;           // LDA 2
    prog[1] = 8'h33;           // ADD 3
    prog[2] = 8'h24;           // STA 4
    prog[3] = 8'h00;           // NOP
    sb.push_back(fd(4'd0));
    sb.push_back(fd(4'd1));
    sb.push_back(ev(4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0));
    sb.push_back(fd(4'd1));
    sb.push_back(fd(4'd2));
    sb.push_back(ev(4'd2, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0));
    sb.push_back(fd(4'd2));
    sb.push_back(fd(4'd3));
    sb.push_back(ev(4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0));
    sb.push_back(fd(4'd3));
    sb.push_back(fd(4'd4));
    sb.push_back(fd(4'd4));
    sb.push_back(fd(4'd5));
    sb.push_back(hl(4'd5));
    sb.push_back(hl(4'd5));
    start = 1'b1;              // held high throughout: must not restart the program
    while (sb.size() > 0) begin
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL back_to_back: got %h want %h", obs, exp_v); end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; zero = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
    test_reset();
    test_lda();
    test_sta();
    test_sub();
    test_jz(1'b1);
    test_jz(1'b0);
    test_pc_wrap();
    test_halt();
    test_reset_in_exec();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
